// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and defaults for the round-robin register arbiter.
// State encoding, default sizing and a ceil-log2 helper for the owner index width.
package rr_reg_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

    localparam int unsigned DefN    = 4;
    localparam int unsigned DefW    = 8;
    localparam int unsigned DefHold = 2;
    // Hold counter width; covers HOLD up to 15
    localparam int unsigned CntW    = 4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// Request/grant bus between N producers and the shared-register arbiter.
// The lock signal exists only when RR_REG_ARB_LOCK_EN is defined.
interface rr_reg_arbiter_if
    import rr_reg_arbiter_pkg::*;
#(
    parameter int unsigned N    = DefN,
    parameter int unsigned W    = DefW,
    parameter int unsigned IDXW = clog2(N)
);
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
`ifdef RR_REG_ARB_LOCK_EN
    logic           lock;
`endif
    logic [N-1:0]   gnt;
    logic [W-1:0]   dout;
    logic           dout_valid;
    logic [IDXW-1:0] owner;
    logic           busy;

`ifdef RR_REG_ARB_LOCK_EN
    modport master (output req, wdata, lock, input gnt, dout, dout_valid, owner, busy);
    modport slave  (input req, wdata, lock, output gnt, dout, dout_valid, owner, busy);
`else
    modport master (output req, wdata, input gnt, dout, dout_valid, owner, busy);
    modport slave  (input req, wdata, output gnt, dout, dout_valid, owner, busy);
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority selector: first set req bit at or after ptr, wrapping
// explicitly at N so non-power-of-2 sizes never select an out-of-range index.
module rr_pick
    import rr_reg_arbiter_pkg::*;
#(
    parameter int unsigned N    = DefN,
    parameter int unsigned IDXW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] sel,
    output logic            any_req
);
    localparam int unsigned SW = IDXW + 1;

    logic [SW-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest set bit wins
    always_comb begin
        sel = '0;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + SW'(i);
            if (idx >= SW'(N)) begin
                idx = idx - SW'(N);
            end
            if (req[idx[IDXW-1:0]]) begin
                sel = idx[IDXW-1:0];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters, holding ownership
// for HOLD cycles per capture. Define RR_REG_ARB_LOCK_EN to add owner lock/recapture.
module rr_reg_arbiter
    import rr_reg_arbiter_pkg::*;
#(
    parameter int unsigned N    = DefN,
    parameter int unsigned W    = DefW,
    parameter int unsigned HOLD = DefHold,
    parameter int unsigned IDXW = clog2(N)
) (
    input logic           clk,
    input logic           rst,
    rr_reg_arbiter_if.slave bus
);
    state_e          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    dout_q, dout_d;
    logic            valid_q, valid_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [N-1:0]    gnt_q, gnt_d;

    logic [IDXW-1:0] sel;
    logic            any_req;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .sel     (sel),
        .any_req (any_req)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        owner_d = owner_q;
        gnt_d   = '0;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    dout_d  = bus.wdata[sel*W +: W];
                    valid_d = 1'b1;
                    owner_d = sel;
                    gnt_d   = N'(1) << sel;
                    ptr_d   = (sel == IDXW'(N - 1)) ? '0 : sel + IDXW'(1);
                    cnt_d   = CntW'(HOLD - 1);
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
`ifdef RR_REG_ARB_LOCK_EN
                    // Locked owner keeps the register; ptr stays put
                    if (bus.lock) begin
                        cnt_d = CntW'(HOLD - 1);
                        if (bus.req[owner_q]) begin
                            dout_d = bus.wdata[owner_q*W +: W];
                            gnt_d  = N'(1) << owner_q;
                        end
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            owner_q <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = (state_q == StHold);

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed self-checking bench for rr_reg_arbiter (N=4, W=8, HOLD=2).
// Lock scenario runs only when RR_REG_ARB_LOCK_EN is defined.
module tb_rr_reg_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    rr_reg_arbiter_if #(.N(4), .W(8), .IDXW(2)) bus ();

    rr_reg_arbiter #(
        .N    (4),
        .W    (8),
        .HOLD (2),
        .IDXW (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] v);
        bus.wdata[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.wdata = '0;
        tick();
        tick();
        checks++;
        if ({bus.gnt, bus.busy, bus.dout_valid, bus.dout, bus.owner} !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got gnt=%b busy=%b valid=%b dout=%h owner=%0d want all 0",
                     bus.gnt, bus.busy, bus.dout_valid, bus.dout, bus.owner);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({bus.gnt, bus.busy, bus.dout_valid, bus.dout} !== 14'h0) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d got gnt=%b busy=%b valid=%b dout=%h want 0",
                         c, bus.gnt, bus.busy, bus.dout_valid, bus.dout);
            end
        end
    endtask

    task automatic test_single();
        set_lane(2, 8'hA5);
        bus.req = 4'b0100;
        tick();
        checks++;
        if (bus.gnt !== 4'b0100 || bus.dout !== 8'hA5 || bus.owner !== 2'd2 ||
            bus.busy !== 1'b1 || bus.dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got gnt=%b dout=%h owner=%0d busy=%b valid=%b want 0100 a5 2 1 1",
                     bus.gnt, bus.dout, bus.owner, bus.busy, bus.dout_valid);
        end
        bus.req = '0;
        tick();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_hold2 got gnt=%b busy=%b want 0000 1", bus.gnt, bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.dout !== 8'hA5) begin
            errors++;
            $display("FAIL single_release got busy=%b dout=%h want 0 a5", bus.busy, bus.dout);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_d;
        do_reset();
        for (int i = 0; i < 4; i++) set_lane(i, 8'(i * 8'h11));
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) begin
                tick();
                tick();
                checks++;
                if (bus.gnt !== 4'b0000) begin
                    errors++;
                    $display("FAIL rotate_gap k=%0d got gnt=%b want 0000", k, bus.gnt);
                end
            end
            tick();
            exp_d = 8'((k % 4) * 8'h11);
            checks++;
            if (bus.gnt !== 4'(1 << (k % 4)) || bus.dout !== exp_d || bus.owner !== 2'(k % 4)) begin
                errors++;
                $display("FAIL rotate_grant k=%0d got gnt=%b dout=%h owner=%0d want %b %h %0d",
                         k, bus.gnt, bus.dout, bus.owner, 4'(1 << (k % 4)), exp_d, k % 4);
            end
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        // ptr is 1 here; grant 2 leaves ptr at 3
        set_lane(0, 8'h5A);
        set_lane(2, 8'h2B);
        set_lane(3, 8'hC3);
        bus.req = 4'b0100;
        tick();
        checks++;
        if (bus.gnt !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_pre got gnt=%b want 0100", bus.gnt);
        end
        bus.req = 4'b1001;
        tick();
        tick();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_held got gnt=%b busy=%b want 0000 0", bus.gnt, bus.busy);
        end
        tick();
        checks++;
        if (bus.gnt !== 4'b1000 || bus.dout !== 8'hC3 || bus.owner !== 2'd3) begin
            errors++;
            $display("FAIL wrap_first got gnt=%b dout=%h owner=%0d want 1000 c3 3",
                     bus.gnt, bus.dout, bus.owner);
        end
        bus.req = 4'b0001;
        tick();
        tick();
        tick();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.dout !== 8'h5A || bus.owner !== 2'd0) begin
            errors++;
            $display("FAIL wrap_second got gnt=%b dout=%h owner=%0d want 0001 5a 0",
                     bus.gnt, bus.dout, bus.owner);
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_hold();
        set_lane(1, 8'h77);
        bus.req = 4'b0010;
        tick();
        checks++;
        if (bus.gnt !== 4'b0010 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got gnt=%b busy=%b want 0010 1", bus.gnt, bus.busy);
        end
        rst = 1'b1;
        bus.req = 4'b1000;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.dout !== 8'h00 || bus.owner !== 2'd0 ||
            bus.gnt !== 4'b0000 || bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear got busy=%b dout=%h owner=%0d gnt=%b valid=%b want 0 00 0 0000 0",
                     bus.busy, bus.dout, bus.owner, bus.gnt, bus.dout_valid);
        end
        tick();
        checks++;
        if (bus.gnt !== 4'b1000 || bus.dout !== 8'hC3 || bus.owner !== 2'd3) begin
            errors++;
            $display("FAIL midrst_regrant got gnt=%b dout=%h owner=%0d want 1000 c3 3",
                     bus.gnt, bus.dout, bus.owner);
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        // Single requester holding req gets a grant every HOLD+1 cycles
        do_reset();
        set_lane(1, 8'h3C);
        bus.req = 4'b0010;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.gnt !== 4'b0010 || bus.dout !== 8'h3C) begin
                errors++;
                $display("FAIL b2b_grant k=%0d got gnt=%b dout=%h want 0010 3c",
                         k, bus.gnt, bus.dout);
            end
            tick();
            tick();
            checks++;
            if (bus.gnt !== 4'b0000) begin
                errors++;
                $display("FAIL b2b_gap k=%0d got gnt=%b want 0000", k, bus.gnt);
            end
            tick();
        end
        bus.req = '0;
        tick();
        tick();
    endtask

`ifdef RR_REG_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        set_lane(0, 8'h0F);
        set_lane(1, 8'h40);
        bus.req = 4'b0010;
        tick();
        checks++;
        if (bus.gnt !== 4'b0010 || bus.owner !== 2'd1) begin
            errors++;
            $display("FAIL lock_first got gnt=%b owner=%0d want 0010 1", bus.gnt, bus.owner);
        end
        bus.req = 4'b0011;
        bus.lock = 1'b1;
        for (int p = 0; p < 3; p++) begin
            set_lane(1, 8'(8'h41 + p));
            tick();
            checks++;
            if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL lock_gap p=%0d got gnt=%b busy=%b want 0000 1", p, bus.gnt, bus.busy);
            end
            tick();
            checks++;
            if (bus.gnt !== 4'b0010 || bus.dout !== 8'(8'h41 + p) || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL lock_recap p=%0d got gnt=%b dout=%h busy=%b want 0010 %h 1",
                         p, bus.gnt, bus.dout, bus.busy, 8'(8'h41 + p));
            end
        end
        bus.lock = 1'b0;
        bus.req = 4'b0001;
        tick();
        tick();
        tick();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.dout !== 8'h0F || bus.owner !== 2'd0) begin
            errors++;
            $display("FAIL lock_release got gnt=%b dout=%h owner=%0d want 0001 0f 0",
                     bus.gnt, bus.dout, bus.owner);
        end
        bus.req = '0;
        tick();
        tick();
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.wdata = '0;
`ifdef RR_REG_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        test_reset();
        test_single();
        test_rotate();
        test_wrap();
        test_reset_mid_hold();
        test_back_to_back();
`ifdef RR_REG_ARB_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one W-bit storage register (synchronous-reset D flip-flop bank) among N requesters.
- Selects one requester, captures its data into the shared register, then holds ownership for HOLD cycles before it arbitrates again.
- Sits between N producer blocks and any single consumer of the shared register value.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, data width of each requester and of the shared register
- HOLD, 2, cycles the register stays owned after a capture (1..15)
- IDXW, 2, width of owner index; must equal ceil(log2(N))

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N  request vector; bit i = requester i wants the register
- wdata  input  N*W  packed data; requester i occupies bits [i*W +: W]
- gnt  output  N  one-hot grant pulse, high for one cycle when requester i's data is captured
- dout  output  W  shared register contents
- dout_valid  output  1  high once any data has been captured since reset
- owner  output  IDXW  index of the last granted requester
- busy  output  1  high while in HOLD state

Behaviour:
- Reset: rst is sampled only at posedge clk.
  - On reset: gnt=0, dout=0, dout_valid=0, owner=0, busy=0, state=IDLE, ptr=0, cnt=0.
  - A reset mid-HOLD aborts the hold. The next cycle is IDLE with ptr=0.
- States: IDLE and HOLD.
- IDLE:
  - With req==0: stay IDLE, gnt=0.
  - With any req bit set: pick sel = first set bit searching ptr, ptr+1, ... N-1, 0, ... (wrap-around).
  - At the clock edge: dout<=wdata[sel], dout_valid<=1, owner<=sel, gnt<=(1<<sel), ptr<=(sel+1) mod N, cnt<=HOLD-1, busy<=1, state<=HOLD.
- Latency: req sampled at edge k gives gnt and new dout visible after edge k (one cycle).
- HOLD:
  - gnt=0 and req is ignored.
  - If cnt!=0, cnt decrements.
  - If cnt==0, state<=IDLE and busy<=0.
  - HOLD lasts exactly HOLD cycles. The minimum spacing between consecutive grants is HOLD+1 cycles.
- Handshake: requester i keeps req[i] and wdata stable until it sees gnt[i]=1.
  - It drops req[i] in the gnt cycle, or keeps it asserted to queue another transfer.
  - Dropping req before grant withdraws the request without any side effect.
- Fairness: ptr advances past the winner only. With all N requesting continuously, grants rotate 0,1,...,N-1,0. No requester waits more than N arbitration rounds.
- Simultaneous req and exit from HOLD: requests are evaluated only in IDLE. The IDLE cycle that follows HOLD arbitrates normally.
- dout holds its value between captures. It is never cleared except by rst.
- ptr wraps from N-1 to 0. Non-power-of-2 N must wrap explicitly, not by truncation.

Optional Feature:
- Macro: RR_REG_ARB_LOCK_EN.
- Defined:
  - Adds input lock (1 bit).
  - If lock=1 on the final HOLD cycle (cnt==0), the FSM stays in HOLD with cnt reloaded to HOLD-1.
  - If additionally req[owner]=1, it recaptures wdata[owner] and pulses gnt[owner].
  - The owner keeps the register as long as lock stays high. ptr is not advanced during lock.
- Undefined: no lock port, and behaviour is exactly as described above.

Decomposition:
- Shared package/header: state encodings IDLE=1'b0 and HOLD=1'b1, default N/W/HOLD constants, and a ceil-log2 function for IDXW.
- One sub-module: rr_pick. It is a combinational rotate-priority selector taking req and ptr and returning sel and any_req. It is instantiated once; the FSM, counter and shared register live in the top.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then req=0 for 5 cycles -> dout=0, dout_valid=0, gnt=0, busy=0 throughout.
- Single request: req=4'b0100, wdata[2]=8'hA5 -> one cycle later gnt=4'b0100, dout=8'hA5, owner=2, busy=1 for 2 cycles, then busy=0.
- All requesting continuously with HOLD=2, data i*8'h11 -> grants 0,1,2,3,0 spaced 3 cycles apart, and dout follows 00,11,22,33,00.
- Wrap priority: ptr=3 after granting 2, then req=4'b1001 -> grant 3 first, then 0.
- Reset mid-HOLD: rst asserted during busy=1 -> next cycle busy=0, dout=0, owner=0, and req=4'b1000 is then granted after IDLE is re-entered.
- RR_REG_ARB_LOCK_EN defined: owner 1 with lock=1 and req[1]=1 for 3 hold periods while req[0]=1 -> gnt[1] pulses every HOLD cycles and gnt[0] stays 0. After lock drops, req[0] is granted.
